// File: rtl/led_bar_pkg.sv
// Shared types and constants for the LED bar arbiter: FSM state encoding,
// bar-owner encoding and the default bar width.
package led_bar_pkg;

  localparam int unsigned DefaultWidth = 16;

  localparam logic OWN_FLASH = 1'b0;
  localparam logic OWN_DIAG  = 1'b1;

  typedef enum logic [1:0] {
    StFlash,
    StBlankToDiag,
    StDiag,
    StBlankToFlash
  } arb_state_e;

endpackage

// File: rtl/led_bar_arbiter_if.sv
// Bar-side signal bundle between the flasher/diagnostic requesters (master)
// and the arbiter that drives the lamps (slave).
interface led_bar_arbiter_if
  import led_bar_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
);

  logic [WIDTH-1:0] flash_led;
  logic             step_en;
  logic             diag_req;
  logic [WIDTH-1:0] diag_led;
  logic             diag_gnt;
  logic             timeout;
  logic             owner;
  logic [WIDTH-1:0] led_out;

  modport master (
    output flash_led,
    output diag_req,
    output diag_led,
    input  step_en,
    input  diag_gnt,
    input  timeout,
    input  owner,
    input  led_out
  );

  modport slave (
    input  flash_led,
    input  diag_req,
    input  diag_led,
    output step_en,
    output diag_gnt,
    output timeout,
    output owner,
    output led_out
  );

endinterface

// File: rtl/step_prescaler.sv
// Free-running 0..PRESCALE-1 counter that advances only while run is high;
// tc marks the terminal-count cycle.
module step_prescaler #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tc
);

  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(PRESCALE - 1);

  logic [CntW-1:0] cnt_q;

  assign tc = run && (cnt_q == CntLast);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= tc ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/led_bar_arbiter.sv
// Shares the LED bar between the bound flasher and a diagnostic source,
// switching only on step boundaries with a blank cycle and a bounded hold.
module led_bar_arbiter
  import led_bar_pkg::*;
#(
  parameter int unsigned WIDTH    = DefaultWidth,
  parameter int unsigned PRESCALE = 4,
  parameter int unsigned MAX_HOLD = 64
) (
  input  logic             clk,
  input  logic             rst,
  led_bar_arbiter_if.slave bus
);

  localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(MAX_HOLD - 1);

  arb_state_e       state_q;
  logic [HoldW-1:0] hold_q;
  logic             lock_q;
  logic             step_en_q;
  logic             diag_gnt_q;
  logic             timeout_q;
  logic             owner_q;
  logic [WIDTH-1:0] led_q;
  logic             tc;

  step_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_step_prescaler (
    .clk(clk),
    .rst(rst),
    .run(state_q == StFlash),
    .tc (tc)
  );

  // led_out is loaded from the source of the state being entered, so the bar,
  // owner and diag_gnt all change together on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StFlash;
      hold_q     <= '0;
      lock_q     <= 1'b0;
      step_en_q  <= 1'b0;
      diag_gnt_q <= 1'b0;
      timeout_q  <= 1'b0;
      owner_q    <= OWN_FLASH;
      led_q      <= '0;
    end else begin
      step_en_q <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        StFlash: begin
          led_q <= bus.flash_led;
          if (!bus.diag_req) lock_q <= 1'b0;
          if (tc) begin
            if (bus.diag_req && !lock_q) begin
              state_q <= StBlankToDiag;
              hold_q  <= '0;
              led_q   <= '0;
            end else begin
              step_en_q <= 1'b1;
            end
          end
        end
        StBlankToDiag: begin
          state_q    <= StDiag;
          diag_gnt_q <= 1'b1;
          owner_q    <= OWN_DIAG;
          led_q      <= bus.diag_led;
        end
        StDiag: begin
          led_q <= bus.diag_led;
          if (!bus.diag_req || (hold_q == HoldLast)) begin
            state_q    <= StBlankToFlash;
            diag_gnt_q <= 1'b0;
            owner_q    <= OWN_FLASH;
            led_q      <= '0;
            // A request dropped on the last allowed cycle is a clean release.
            if (bus.diag_req) begin
              timeout_q <= 1'b1;
              lock_q    <= 1'b1;
            end
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        StBlankToFlash: begin
          state_q <= StFlash;
          led_q   <= bus.flash_led;
        end
        default: begin
          state_q <= StFlash;
          led_q   <= '0;
        end
      endcase
    end
  end

  assign bus.step_en  = step_en_q;
  assign bus.diag_gnt = diag_gnt_q;
  assign bus.timeout  = timeout_q;
  assign bus.owner    = owner_q;
  assign bus.led_out  = led_q;

endmodule

// File: doc/led_bar_arbiter.md
Name: led_bar_arbiter

Overview:
- Owns the 16-lamp LED bar and shares it between two requesters: the bound-flasher datapath (default owner) and a diagnostic/host pattern source.
- Generates the flasher's step-enable tick from a prescaler. The flasher advances only when it owns the bar, and pauses while diagnostics holds it.
- Hands the bar over only on step boundaries, with a one-cycle blank in each direction. Diagnostic hold time is bounded by a timeout with lockout.

Parameters:
- WIDTH, 16, LED bar width.
- PRESCALE, 4, clk cycles per flasher step (≥1).
- MAX_HOLD, 64, maximum cycles diagnostics may own the bar per grant (≥2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- flash_led  in  WIDTH  lamp pattern from the flasher.
- step_en  out  1  one-cycle pulse; the flasher advances one step.
- diag_req  in  1  level request from the diagnostic source.
- diag_led  in  WIDTH  diagnostic lamp pattern.
- diag_gnt  out  1  high while diagnostics owns the bar.
- timeout  out  1  one-cycle pulse when a grant is force-revoked.
- owner  out  1  0 = flasher, 1 = diagnostics (high in DIAG only).
- led_out  out  WIDTH  registered bar drive.

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values: state FLASH, led_out 0, step_en 0, diag_gnt 0, timeout 0, owner 0, prescaler 0, hold counter 0, lock 0.
- Reset mid-operation (any state, including DIAG) returns to the reset state at the next edge. diag_gnt drops the same edge.
- States: FLASH, BLANK_TO_DIAG, DIAG, BLANK_TO_FLASH.
- Outputs per state:
  - led_out is registered, 1-cycle latency.
  - FLASH: led_out <= flash_led.
  - BLANK_*: led_out <= 0.
  - DIAG: led_out <= diag_led.
- FLASH:
  - Prescaler runs 0..PRESCALE-1 and is frozen in every other state.
  - At terminal count the prescaler returns to 0.
  - If diag_req=1 and lock=0: go to BLANK_TO_DIAG and do not pulse step_en.
  - Otherwise: step_en <= 1 for exactly one cycle.
  - Result: step_en period is PRESCALE cycles. With PRESCALE=1, step_en is high every FLASH cycle.
- BLANK_TO_DIAG: one cycle, then DIAG. diag_gnt <= 1 and hold counter <= 0 on entry.
- DIAG:
  - Hold counter increments every cycle.
  - If diag_req=0: go to BLANK_TO_FLASH, diag_gnt <= 0.
  - Else if hold counter == MAX_HOLD-1: go to BLANK_TO_FLASH, diag_gnt <= 0, timeout pulse, lock <= 1.
  - Simultaneous request drop and timeout: the drop wins, no timeout, no lock.
- BLANK_TO_FLASH: one cycle, then FLASH with prescaler 0. The flasher receives a full PRESCALE period before its next step.
- Lock:
  - While lock=1, diag_req is ignored.
  - lock clears on any FLASH cycle with diag_req=0.
  - If the request is still held, the source must drop it and re-raise to be granted again.
- diag_req arriving mid-period waits for the next terminal count. Worst-case grant latency: PRESCALE+1 cycles.
- No step_en is issued outside FLASH, so the flasher pattern is preserved across a diagnostic episode.
- Counter widths: $clog2 of (max parameter + 1). No wrap beyond the terminal values.

Decomposition:
- Shared package led_bar_pkg:
  - state enum (FLASH, BLANK_TO_DIAG, DIAG, BLANK_TO_FLASH).
  - owner encoding constants OWN_FLASH=0, OWN_DIAG=1.
  - default WIDTH=16.
- One sub-module, step_prescaler:
  - inputs clk, rst, run.
  - output tc, terminal-count strobe.
  - parameter PRESCALE.
- FSM, hold counter, lock and output registers stay in led_bar_arbiter.

Test Plan (PRESCALE=4, MAX_HOLD=8):
- Reset, then flash_led=16'h001F and diag_req=0 → step_en pulses every 4th cycle. led_out=16'h001F one cycle after the input. diag_gnt and owner stay 0.
- diag_req raised 1 cycle after a step_en, held 5 cycles, then dropped:
  - Grant occurs at the next terminal count (no step_en that cycle), then one led_out=0 cycle, then diag_gnt=1 and led_out=diag_led (16'hA5A5).
  - After the drop: one blank cycle, then flash_led resumes, and the next step_en follows 4 cycles after re-entering FLASH.
- diag_req held high continuously:
  - diag_gnt stays high exactly 8 cycles, then timeout pulses once, followed by a blank cycle and return to FLASH.
  - No re-grant while diag_req stays high.
  - After diag_req drops for 1 cycle and re-rises, a grant occurs at the next terminal count.
- diag_req drops on the same cycle the hold counter reaches 7 → release without a timeout pulse, and lock stays 0.
- rst asserted for 1 cycle while in DIAG → next edge: diag_gnt=0, led_out=0, owner=0, prescaler restarts. First step_en comes 4 cycles after rst deasserts.
- Parameter override PRESCALE=1 → step_en is high every FLASH cycle. A request is granted on the cycle after it is seen, with step_en suppressed that cycle.
